// File: rtl/buffer_reader.sv
// RX-side word assembler: drains the UART RX FIFO one byte per pop and packs NB bytes,
// LSB first, into one word. Completion and timeout are reported through sticky flags.
module buffer_reader #(
    parameter int unsigned DATA_LEN       = 8,
    parameter int unsigned DATA_OUT_LEN   = 32,
    parameter int unsigned TIMEOUT_CYCLES = 0
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic                    i_rd,
    input  logic                    i_is_uart_empty,
    input  logic [DATA_LEN-1:0]     i_rd_data,
    output logic                    o_uart_rd,
    output logic                    o_rd_finished,
    output logic                    o_rd_timeout,
    output logic [DATA_OUT_LEN-1:0] o_rd_buffer
);

    localparam int unsigned NB    = DATA_OUT_LEN / DATA_LEN;
    localparam int unsigned PTR_W = $clog2(NB) + 1;
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [PTR_W-1:0] PTR_FULL = PTR_W'(NB);
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT_CYCLES == 0) ? '0 :
                                            CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StRdWait, StRdPop} state_e;

    state_e                  state_q, state_d;
    logic [PTR_W-1:0]        ptr_q, ptr_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [DATA_OUT_LEN-1:0] asm_q, asm_d;
    logic                    uart_rd_q, uart_rd_d;
    logic                    finished_q, finished_d;
    logic                    timeout_q, timeout_d;
    logic [DATA_OUT_LEN-1:0] buffer_q, buffer_d;
    logic                    timeout_hit;

    // Only meaningful on an empty RD_WAIT cycle; the byte path has priority.
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST);

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q    <= StIdle;
            ptr_q      <= '0;
            cnt_q      <= '0;
            asm_q      <= '0;
            uart_rd_q  <= 1'b0;
            finished_q <= 1'b0;
            timeout_q  <= 1'b0;
            buffer_q   <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
            asm_q      <= asm_d;
            uart_rd_q  <= uart_rd_d;
            finished_q <= finished_d;
            timeout_q  <= timeout_d;
            buffer_q   <= buffer_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (i_rd) state_d = StRdWait;
            end
            StRdWait: begin
                if (ptr_q == PTR_FULL)     state_d = StIdle;
                else if (!i_is_uart_empty) state_d = StRdPop;
                else if (timeout_hit)      state_d = StIdle;
            end
            StRdPop: state_d = StRdWait;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        asm_d      = asm_q;
        uart_rd_d  = 1'b0;
        finished_d = finished_q;
        timeout_d  = timeout_q;
        buffer_d   = buffer_q;
        unique case (state_q)
            StIdle: begin
                if (i_rd) begin
                    finished_d = 1'b0;
                    timeout_d  = 1'b0;
                    ptr_d      = '0;
                    cnt_d      = '0;
                end
            end
            StRdWait: begin
                if (ptr_q == PTR_FULL) begin
                    buffer_d   = asm_q;
                    finished_d = 1'b1;
                    ptr_d      = '0;
                end else if (!i_is_uart_empty) begin
                    asm_d[int'(ptr_q) * DATA_LEN +: DATA_LEN] = i_rd_data;
                    uart_rd_d = 1'b1;
                    cnt_d     = '0;
                end else if (TIMEOUT_CYCLES != 0) begin
                    // Partial word is dropped; o_rd_buffer keeps the last good word.
                    if (timeout_hit) begin
                        timeout_d = 1'b1;
                        ptr_d     = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            StRdPop: begin
                ptr_d = ptr_q + PTR_W'(1);
            end
            default: begin
                ptr_d = '0;
            end
        endcase
    end

    assign o_uart_rd     = uart_rd_q;
    assign o_rd_finished = finished_q;
    assign o_rd_timeout  = timeout_q;
    assign o_rd_buffer   = buffer_q;

endmodule

// File: tb/tb_buffer_reader.sv
// Bench for buffer_reader: two instances (no timeout / 16-cycle timeout) driven from
// queue-based FIFOs and compared every cycle against a transaction-level reference model.
module tb_buffer_reader;

    localparam int unsigned NB  = 4;
    localparam int unsigned TO1 = 16;

    logic        i_clk;
    logic        i_reset;
    logic        rd;
    logic        empty0, empty1;
    logic [7:0]  data0, data1;
    logic        pop0, fin0, to0, pop1, fin1, to1;
    logic [31:0] buf0, buf1;

    typedef struct {
        bit          busy;
        bit          popping;
        int          got;
        int          idle;
        logic [31:0] word;
        logic [31:0] rdbuf;
        bit          pop;
        bit          fin;
        bit          to;
    } model_t;

    model_t     m0, m1;
    logic [7:0] fq0[$];
    logic [7:0] fq1[$];
    int         n_tests = 0;
    int         n_fail  = 0;
    int         cyc     = 0;
    int         pops0   = 0;
    int         rises0  = 0;
    bit         prev_pop0, prev_pop1, prev_fin0;

    buffer_reader #(.DATA_LEN(8), .DATA_OUT_LEN(32), .TIMEOUT_CYCLES(0)) u_dut0 (
        .i_clk           (i_clk),
        .i_reset         (i_reset),
        .i_rd            (rd),
        .i_is_uart_empty (empty0),
        .i_rd_data       (data0),
        .o_uart_rd       (pop0),
        .o_rd_finished   (fin0),
        .o_rd_timeout    (to0),
        .o_rd_buffer     (buf0)
    );

    buffer_reader #(.DATA_LEN(8), .DATA_OUT_LEN(32), .TIMEOUT_CYCLES(TO1)) u_dut1 (
        .i_clk           (i_clk),
        .i_reset         (i_reset),
        .i_rd            (rd),
        .i_is_uart_empty (empty1),
        .i_rd_data       (data1),
        .o_uart_rd       (pop1),
        .o_rd_finished   (fin1),
        .o_rd_timeout    (to1),
        .o_rd_buffer     (buf1)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One posedge of the reader as seen from outside: start on request, one byte per
    // two cycles while bytes are available, publish the word one cycle after the last
    // byte, give up after TO consecutive empty waits.
    function automatic model_t model_step(model_t m, int tcyc, bit req, bit empty,
                                          logic [7:0] data);
        model_t n = m;
        n.pop = 1'b0;
        if (!m.busy) begin
            if (req) begin
                n.busy = 1'b1; n.got = 0; n.idle = 0; n.fin = 1'b0; n.to = 1'b0;
            end
        end else if (m.popping) begin
            n.popping = 1'b0;
            n.got     = m.got + 1;
        end else if (m.got == NB) begin
            n.rdbuf = m.word;
            n.fin   = 1'b1;
            n.busy  = 1'b0;
        end else if (!empty) begin
            n.word[8*m.got +: 8] = data;
            n.pop     = 1'b1;
            n.popping = 1'b1;
            n.idle    = 0;
        end else if (tcyc != 0) begin
            n.idle = m.idle + 1;
            if (n.idle == tcyc) begin
                n.to   = 1'b1;
                n.busy = 1'b0;
            end
        end
        return n;
    endfunction

    task automatic check_all();
        check_eq("pop0", 32'(pop0), 32'(m0.pop));
        check_eq("fin0", 32'(fin0), 32'(m0.fin));
        check_eq("to0",  32'(to0),  32'(m0.to));
        check_eq("buf0", buf0, m0.rdbuf);
        check_eq("pop1", 32'(pop1), 32'(m1.pop));
        check_eq("fin1", 32'(fin1), 32'(m1.fin));
        check_eq("to1",  32'(to1),  32'(m1.to));
        check_eq("buf1", buf1, m1.rdbuf);
    endtask

    task automatic tick();
        model_t n0, n1;
        empty0 = (fq0.size() == 0);
        data0  = empty0 ? 8'($urandom) : fq0[0];
        empty1 = (fq1.size() == 0);
        data1  = empty1 ? 8'($urandom) : fq1[0];
        n0 = model_step(m0, 0, rd, empty0, data0);
        n1 = model_step(m1, TO1, rd, empty1, data1);
        @(posedge i_clk);
        #1;
        cyc++;
        m0 = n0;
        m1 = n1;
        check_all();
        check_eq("pop0_b2b", 32'(pop0 & prev_pop0), 32'd0);
        check_eq("pop1_b2b", 32'(pop1 & prev_pop1), 32'd0);
        if (pop0) begin
            pops0++;
            if (fq0.size() > 0) void'(fq0.pop_front());
        end
        if (pop1 && fq1.size() > 0) void'(fq1.pop_front());
        if (fin0 && !prev_fin0) rises0++;
        prev_pop0 = pop0;
        prev_pop1 = pop1;
        prev_fin0 = fin0;
    endtask

    task automatic push_both(input logic [7:0] b);
        fq0.push_back(b);
        fq1.push_back(b);
    endtask

    task automatic flush();
        fq0.delete();
        fq1.delete();
    endtask

    task automatic model_reset();
        m0 = '{default: 0};
        m1 = '{default: 0};
        prev_pop0 = 1'b0;
        prev_pop1 = 1'b0;
        prev_fin0 = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        check_eq({tag, "_pop"}, 32'({pop0, pop1}), 32'd0);
        check_eq({tag, "_flags"}, 32'({fin0, to0, fin1, to1}), 32'd0);
        check_eq({tag, "_buf0"}, buf0, 32'd0);
        check_eq({tag, "_buf1"}, buf1, 32'd0);
    endtask

    task automatic wait_fin0(input string tag, input int bound);
        for (int i = 0; i < bound && !fin0; i++) tick();
        check_eq(tag, 32'(fin0), 32'd1);
    endtask

    initial begin
        logic [7:0]  b[8];
        logic [31:0] w1, w2;
        int          p, fin_hi, r_before;

        i_reset = 1'b0;
        rd      = 1'b0;
        empty0  = 1'b1;
        empty1  = 1'b1;
        data0   = 8'h00;
        data1   = 8'h00;
        model_reset();
        repeat (2) @(posedge i_clk);
        #1;
        check_zero("reset");
        @(negedge i_clk);
        i_reset = 1'b1;

        // 1: pre-loaded FIFO, nominal latency
        flush();
        push_both(8'h78); push_both(8'h56); push_both(8'h34); push_both(8'h12);
        pops0 = 0;
        rd = 1'b1;
        tick();
        rd = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            tick();
            if (i == 8) check_eq("t1_fin_early", 32'(fin0), 32'd0);
        end
        check_eq("t1_fin", 32'(fin0), 32'd1);
        check_eq("t1_word", buf0, 32'h1234_5678);
        check_eq("t1_to", 32'(to0), 32'd0);
        check_eq("t1_pops", pops0, 32'd4);

        // 2: FIFO stalls for 20 cycles after two bytes
        flush();
        push_both(8'h11); push_both(8'h22);
        rd = 1'b1;
        tick();
        rd = 1'b0;
        repeat (4) tick();
        p = pops0;
        repeat (20) tick();
        check_eq("t2_gap_pops", pops0 - p, 32'd0);
        fq0.push_back(8'h33);
        fq0.push_back(8'h44);
        wait_fin0("t2_fin", 20);
        check_eq("t2_word", buf0, 32'h4433_2211);
        check_eq("t2_to1", 32'({to1, fin1}), 32'b10);

        // 3: timeout after one byte on the TIMEOUT_CYCLES=16 instance
        flush();
        push_both(8'hEE);
        rd = 1'b1;
        tick();
        rd = 1'b0;
        repeat (17) tick();
        check_eq("t3_to_early", 32'(to1), 32'd0);
        tick();
        check_eq("t3_to", 32'(to1), 32'd1);
        check_eq("t3_fin", 32'(fin1), 32'd0);
        check_eq("t3_buf_held", buf1, 32'h1234_5678);
        fq0.push_back(8'h01); fq0.push_back(8'h02); fq0.push_back(8'h03);
        wait_fin0("t3_fin0", 20);
        check_eq("t3_word0", buf0, 32'h0302_01EE);

        // 4: requests during an active read are ignored
        flush();
        push_both(8'h9A); push_both(8'hBC); push_both(8'hDE); push_both(8'hF0);
        rd = 1'b1;
        tick();
        check_eq("t4_to_clear", 32'(to1), 32'd0);
        pops0  = 0;
        rises0 = 0;
        for (int i = 1; i <= 14; i++) begin
            rd = (i == 2 || i == 5);
            tick();
        end
        rd = 1'b0;
        check_eq("t4_pops", pops0, 32'd4);
        check_eq("t4_done", rises0, 32'd1);
        check_eq("t4_word", buf0, 32'hF0DE_BC9A);

        // 5: asynchronous reset mid-word, then a clean read
        flush();
        for (int i = 0; i < 4; i++) push_both(8'($urandom));
        rd = 1'b1;
        tick();
        rd = 1'b0;
        repeat (4) tick();
        #3;
        i_reset = 1'b0;
        #1;
        model_reset();
        check_zero("t5_async");
        repeat (3) begin
            @(posedge i_clk);
            #1;
            check_eq("t5_no_pop", 32'({pop0, pop1}), 32'd0);
        end
        @(negedge i_clk);
        i_reset = 1'b1;
        flush();
        push_both(8'hDD); push_both(8'hCC); push_both(8'hBB); push_both(8'hAA);
        rd = 1'b1;
        tick();
        rd = 1'b0;
        repeat (10) tick();
        check_eq("t5_word0", buf0, 32'hAABB_CCDD);
        check_eq("t5_word1", buf1, 32'hAABB_CCDD);

        // 6: i_rd held high across two back-to-back reads
        flush();
        for (int i = 0; i < 8; i++) begin
            b[i] = 8'($urandom);
            push_both(b[i]);
        end
        w1 = {b[3], b[2], b[1], b[0]};
        w2 = {b[7], b[6], b[5], b[4]};
        pops0  = 0;
        rises0 = 0;
        fin_hi = 0;
        rd = 1'b1;
        for (int i = 0; i < 40 && rises0 < 2; i++) begin
            r_before = rises0;
            tick();
            if (rises0 != r_before) begin
                if (rises0 == 1) check_eq("t6_word1", buf0, w1);
                else             check_eq("t6_word2", buf0, w2);
            end
            if (fin0 && rises0 == 1) fin_hi++;
        end
        rd = 1'b0;
        check_eq("t6_done", rises0, 32'd2);
        check_eq("t6_pops", pops0, 32'd8);
        check_eq("t6_fin_width", fin_hi, 32'd1);

        // Random traffic: sporadic requests, bursty FIFO fill
        flush();
        for (int i = 0; i < 400; i++) begin
            rd = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 3) != 0 && fq0.size() < 6 && fq1.size() < 6)
                push_both(8'($urandom));
            else if ($urandom_range(0, 15) == 0)
                repeat (20) begin
                    rd = 1'b0;
                    tick();
                end
            tick();
        end
        rd = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
